pointer_datapath: RTL and testbench
===================================

Name: pointer_datapath

Overview:
- Datapath stage directly downstream of the GoBang control FSM.
- Consumes the FSM's change_turn, change_able_read and control_set strobes, plus the raw put and direction buttons.
- Owns the board cursor (pointer) position, the current player, and the legality flag for the pending put.
- Issues single-cycle write requests to the external board memory and exposes pointer/player state to the VGA/display logic.

Parameters:
- BOARD_DIM, 15: board side length in cells; legal coordinates are 0..BOARD_DIM-1.
- COORD_W, 4: coordinate width; must satisfy 2^COORD_W >= BOARD_DIM.
- REPEAT_CYCLES, 12500000: auto-repeat period in clock cycles (optional feature only).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- move_up  in  1  direction button level, already synchronised.
- move_down  in  1  direction button level.
- move_left  in  1  direction button level.
- move_right  in  1  direction button level.
- put  in  1  put button level; the same signal is fed to the control FSM.
- change_turn  in  1  from control FSM: change-player strobe.
- change_able_read  in  1  from control FSM: high in the CHOICE state.
- control_set  in  1  from control FSM: re-centre pointer strobe.
- cell_rd_data  in  2  board contents at (ptr_x, ptr_y), combinational from board memory; 0 = empty, 1 = black, 2 = white.
- ptr_x  out  COORD_W  pointer column.
- ptr_y  out  COORD_W  pointer row.
- player  out  1  0 = black to move, 1 = white to move.
- legal_put  out  1  the last put landed on an empty cell; valid until the next change_turn.
- wr_en  out  1  board write strobe, one cycle.
- wr_x  out  COORD_W  write column.
- wr_y  out  COORD_W  write row.
- wr_data  out  2  stone value to write: player+1.

Behaviour:
- Reset values (asynchronous on reset high):
  - ptr_x = ptr_y = CENTRE, where CENTRE = BOARD_DIM/2 (7 at default).
  - player = 0, legal_put = 0, wr_en = 0, wr_x = wr_y = 0, wr_data = 0.
  - All edge-detect registers = 0.
- Edge detection: every button input is registered once. A rise is defined as level & ~level_q.
- Movement:
  - Applied only in a cycle where change_able_read=1 and a direction rise is detected.
  - One step per rise. The pointer updates on the clock edge following the rise cycle.
  - Clamp at board edges, no wrap: up at y=0, down at y=BOARD_DIM-1, left at x=0 and right at x=BOARD_DIM-1 all leave the coordinate unchanged.
  - Simultaneous rises: priority up > down > left > right. Only one axis moves per cycle.
  - Direction rises while change_able_read=0 are discarded, not queued.
- Put capture:
  - Triggered by a put rise in a cycle with change_able_read=1.
  - On the next edge, legal_put <= (cell_rd_data == 0).
  - If legal, in that same edge: wr_en <= 1, wr_x/wr_y <= current ptr, wr_data <= player+1.
  - wr_en deasserts on the following edge, so it is exactly one cycle wide.
  - An illegal put produces no write.
  - A put rise while change_able_read=0 is ignored.
- Change:
  - When change_turn=1: if legal_put=1, player toggles; legal_put clears to 0 unconditionally.
  - When control_set=1: ptr_x/ptr_y <= CENTRE. This takes priority over any movement in the same cycle.
- Simultaneous put rise and direction rise in the same cycle: the put is captured against the pre-move pointer, and the move is discarded.
- Reset mid-operation, including during a wr_en pulse: all outputs return to their reset values immediately; no write completes.

Optional Feature:
- POINTER_AUTOREPEAT_EN
- Defined:
  - Holding a single direction button continuously (level high, change_able_read=1) issues an additional step every REPEAT_CYCLES cycles after the initial step.
  - The repeat counter resets on release, on any new rise, and on control_set.
- Undefined:
  - No repeat counter is instantiated; exactly one step per press.

Decomposition:
- Shared package gobang_pkg holds:
  - The cell encoding constants CELL_EMPTY=0, CELL_BLACK=1, CELL_WHITE=2.
  - The player encoding PLAYER_BLACK=0, PLAYER_WHITE=1.
  - BOARD_DIM and COORD_W defaults.
- One natural sub-module: btn_edge. It registers a level input and outputs a rise pulse, and is instantiated five times (four directions plus put).

Test Plan:
- Reset, then 3 right rises and 2 down rises with change_able_read=1 -> ptr = (10,9), player=0, wr_en never asserted.
- From ptr (0,0): up rise then left rise -> ptr stays (0,0). From (14,14): down and right rises -> ptr stays (14,14).
- cell_rd_data=0 at (7,7), put rise in CHOICE -> next cycle legal_put=1 and a single-cycle wr_en with wr_x=7, wr_y=7, wr_data=1. Then change_turn -> player=1, legal_put=0.
- cell_rd_data=2, put rise -> legal_put=0 and no wr_en. Then change_turn -> player stays 0.
- Pointer at (3,12), control_set pulse coincident with a right rise -> ptr = (7,7).
- Assert reset during the wr_en cycle -> wr_en=0, ptr=(7,7) and player=0 in the same cycle. Release reset -> outputs hold their reset values until the next button rise.

Source files
------------

// File: rtl/gobang_pkg.sv
// Shared GoBang encodings: cell contents, player identity and board geometry defaults.
package gobang_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'd0;
    localparam cell_t CELL_BLACK = 2'd1;
    localparam cell_t CELL_WHITE = 2'd2;

    localparam logic PLAYER_BLACK = 1'b0;
    localparam logic PLAYER_WHITE = 1'b1;

    localparam int GB_BOARD_DIM = 15;
    localparam int GB_COORD_W   = 4;

endpackage

// File: rtl/pointer_datapath_btn_edge.sv
// Button rise detector: registers the level once and flags level & ~level_q.
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    // Previous-cycle copy of the button level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/pointer_datapath.sv
// GoBang pointer/player datapath: cursor movement with edge clamping, put
// legality capture, single-cycle board write strobe and player turnover.
// Optional build macro POINTER_AUTOREPEAT_EN adds hold-to-repeat movement.
module pointer_datapath
    import gobang_pkg::*;
#(
    parameter int BOARD_DIM = GB_BOARD_DIM,
    parameter int COORD_W   = GB_COORD_W
`ifdef POINTER_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES = 12500000
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               move_up,
    input  logic               move_down,
    input  logic               move_left,
    input  logic               move_right,
    input  logic               put,
    input  logic               change_turn,
    input  logic               change_able_read,
    input  logic               control_set,
    input  logic [1:0]         cell_rd_data,
    output logic [COORD_W-1:0] ptr_x,
    output logic [COORD_W-1:0] ptr_y,
    output logic               player,
    output logic               legal_put,
    output logic               wr_en,
    output logic [COORD_W-1:0] wr_x,
    output logic [COORD_W-1:0] wr_y,
    output logic [1:0]         wr_data
);

    localparam logic [COORD_W-1:0] CENTRE   = COORD_W'(BOARD_DIM / 2);
    localparam logic [COORD_W-1:0] EDGE_MAX = COORD_W'(BOARD_DIM - 1);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

    logic up_rise, down_rise, left_rise, right_rise, put_rise;
    logic req_up, req_down, req_left, req_right;
    logic put_capture, cell_empty, move_ok;
    logic [COORD_W-1:0] next_x, next_y;

    btn_edge u_edge_up    (.clock(clock), .reset(reset), .level(move_up),    .rise(up_rise));
    btn_edge u_edge_down  (.clock(clock), .reset(reset), .level(move_down),  .rise(down_rise));
    btn_edge u_edge_left  (.clock(clock), .reset(reset), .level(move_left),  .rise(left_rise));
    btn_edge u_edge_right (.clock(clock), .reset(reset), .level(move_right), .rise(right_rise));
    btn_edge u_edge_put   (.clock(clock), .reset(reset), .level(put),        .rise(put_rise));

    assign put_capture = change_able_read & put_rise;
    assign cell_empty  = (cell_rd_data == CELL_EMPTY);
    // A put in the same cycle pins the pointer so the write uses the pre-move cell.
    assign move_ok     = change_able_read & ~put_capture;

`ifdef POINTER_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LOAD = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic          any_rise, held_single, rep_fire;

    assign any_rise    = up_rise | down_rise | left_rise | right_rise;
    assign held_single = change_able_read & $onehot({move_up, move_down, move_left, move_right});
    assign rep_fire    = held_single & ~any_rise & (rep_cnt == '0);

    // Repeat down-counter: reloads on any new press, release or re-centre, fires at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rep_cnt <= REP_LOAD;
        end else if (any_rise | ~held_single | control_set) begin
            rep_cnt <= REP_LOAD;
        end else if (rep_cnt == '0) begin
            rep_cnt <= REP_LOAD;
        end else begin
            rep_cnt <= rep_cnt - RW'(1);
        end
    end

    assign req_up    = up_rise    | (rep_fire & move_up);
    assign req_down  = down_rise  | (rep_fire & move_down);
    assign req_left  = left_rise  | (rep_fire & move_left);
    assign req_right = right_rise | (rep_fire & move_right);
`else
    assign req_up    = up_rise;
    assign req_down  = down_rise;
    assign req_left  = left_rise;
    assign req_right = right_rise;
`endif

    // Next pointer: re-centre wins, else one clamped step with up > down > left > right.
    always_comb begin
        next_x = ptr_x;
        next_y = ptr_y;
        if (control_set) begin
            next_x = CENTRE;
            next_y = CENTRE;
        end else if (move_ok) begin
            if (req_up) begin
                if (ptr_y != '0) next_y = ptr_y - ONE;
            end else if (req_down) begin
                if (ptr_y != EDGE_MAX) next_y = ptr_y + ONE;
            end else if (req_left) begin
                if (ptr_x != '0) next_x = ptr_x - ONE;
            end else if (req_right) begin
                if (ptr_x != EDGE_MAX) next_x = ptr_x + ONE;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_x <= CENTRE;
            ptr_y <= CENTRE;
        end else begin
            ptr_x <= next_x;
            ptr_y <= next_y;
        end
    end

    // Player turnover and put legality; a capture overrides a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            player    <= PLAYER_BLACK;
            legal_put <= 1'b0;
        end else begin
            if (change_turn) begin
                if (legal_put) player <= ~player;
                legal_put <= 1'b0;
            end
            if (put_capture) legal_put <= cell_empty;
        end
    end

    // Board write request: one-cycle strobe, address/data held until the next write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_x    <= '0;
            wr_y    <= '0;
            wr_data <= CELL_EMPTY;
        end else begin
            wr_en <= put_capture & cell_empty;
            if (put_capture & cell_empty) begin
                wr_x    <= ptr_x;
                wr_y    <= ptr_y;
                wr_data <= (player == PLAYER_WHITE) ? CELL_WHITE : CELL_BLACK;
            end
        end
    end

endmodule

// File: tb/tb_pointer_datapath.sv
// Bench for pointer_datapath: directed literal checks followed by randomized
// stimulus compared every cycle against a behavioural board/pointer model.
module tb_pointer_datapath;

    localparam int N = 15;
    localparam int C = 7;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0;
    logic       put = 1'b0, change_turn = 1'b0, change_able_read = 1'b0, control_set = 1'b0;
    logic [1:0] cell_rd_data;
    logic [3:0] ptr_x, ptr_y, wr_x, wr_y;
    logic       player, legal_put, wr_en;
    logic [1:0] wr_data;

    // external board memory owned by the bench
    logic [1:0] board [0:N-1][0:N-1];
    logic       fill_en = 1'b0, fill_zero = 1'b1, poke_en = 1'b0;
    logic [3:0] poke_x = '0, poke_y = '0;
    logic [1:0] poke_v = '0;
    int         wr_seen = 0;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int         mx, my, mplayer, mlegal, mwen, mwx, mwy, mwd;
    int         mboard [0:N-1][0:N-1];
    bit [4:0]   prev;

    always #10 clock = ~clock;

    pointer_datapath dut (
        .clock(clock), .reset(reset),
        .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
        .put(put), .change_turn(change_turn), .change_able_read(change_able_read),
        .control_set(control_set), .cell_rd_data(cell_rd_data),
        .ptr_x(ptr_x), .ptr_y(ptr_y), .player(player), .legal_put(legal_put),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data)
    );

    assign cell_rd_data = (ptr_x < 4'(N) && ptr_y < 4'(N)) ? board[ptr_y][ptr_x] : 2'd3;

    function automatic logic [1:0] fill_val(input int x, input int y);
        int h;
        h = (x * 5 + y * 11 + x * y) % 4;
        return (h == 3) ? 2'd0 : 2'(h);
    endfunction

    always @(posedge clock) begin
        if (fill_en) begin
            for (int y = 0; y < N; y++)
                for (int x = 0; x < N; x++)
                    board[y][x] <= fill_zero ? 2'd0 : fill_val(x, y);
        end else if (poke_en) begin
            board[poke_y][poke_x] <= poke_v;
        end else if (wr_en) begin
            board[wr_y][wr_x] <= wr_data;
        end
        if (wr_en) wr_seen <= wr_seen + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic press(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            case (d)
                0: move_up = 1'b1;
                1: move_down = 1'b1;
                2: move_left = 1'b1;
                3: move_right = 1'b1;
                default: put = 1'b1;
            endcase
            tick();
            move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0; put = 1'b0;
            tick();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".ptr_x"}, ptr_x, C);
        check({tag, ".ptr_y"}, ptr_y, C);
        check({tag, ".player"}, player, 0);
        check({tag, ".legal_put"}, legal_put, 0);
        check({tag, ".wr_en"}, wr_en, 0);
        check({tag, ".wr_x"}, wr_x, 0);
        check({tag, ".wr_y"}, wr_y, 0);
        check({tag, ".wr_data"}, wr_data, 0);
    endtask

    task automatic model_reset();
        mx = C; my = C; mplayer = 0; mlegal = 0;
        mwen = 0; mwx = 0; mwy = 0; mwd = 0;
        prev = '0;
    endtask

    // Model of the next clock edge given the inputs currently applied.
    task automatic model_step();
        bit r_up, r_dn, r_lt, r_rt, r_put;
        int old_player, old_legal;
        r_up  = move_up    & ~prev[0];
        r_dn  = move_down  & ~prev[1];
        r_lt  = move_left  & ~prev[2];
        r_rt  = move_right & ~prev[3];
        r_put = put        & ~prev[4];
        old_player = mplayer;
        old_legal  = mlegal;
        mwen = 0;
        if (change_turn) begin
            if (old_legal != 0) mplayer = 1 - mplayer;
            mlegal = 0;
        end
        if (change_able_read && r_put) begin
            mlegal = (mboard[my][mx] == 0) ? 1 : 0;
            if (mlegal != 0) begin
                mwen = 1; mwx = mx; mwy = my; mwd = old_player + 1;
            end
        end
        if (control_set) begin
            mx = C; my = C;
        end else if (change_able_read && !r_put) begin
            if (r_up)      begin if (my > 0)     my--; end
            else if (r_dn) begin if (my < N - 1) my++; end
            else if (r_lt) begin if (mx > 0)     mx--; end
            else if (r_rt) begin if (mx < N - 1) mx++; end
        end
        prev = {put, move_right, move_left, move_down, move_up};
    endtask

    task automatic compare_model();
        check("m.ptr_x", ptr_x, mx);
        check("m.ptr_y", ptr_y, my);
        check("m.player", player, mplayer);
        check("m.legal_put", legal_put, mlegal);
        check("m.wr_en", wr_en, mwen);
        check("m.wr_x", wr_x, mwx);
        check("m.wr_y", wr_y, mwy);
        check("m.wr_data", wr_data, mwd);
    endtask

    initial begin
        // reset with zero board
        @(negedge clock);
        reset = 1'b1; fill_en = 1'b1; fill_zero = 1'b1;
        #1;
        check_reset_vals("reset");
        tick();
        fill_en = 1'b0; reset = 1'b0;
        tick();
        check_reset_vals("post_reset");

        // basic movement
        change_able_read = 1'b1;
        press(3, 3);
        press(1, 2);
        check("move.x", ptr_x, 10);
        check("move.y", ptr_y, 9);
        check("move.player", player, 0);
        check("move.no_write", wr_seen, 0);

        // clamps at (0,0)
        press(2, 10);
        press(0, 9);
        check("to00.x", ptr_x, 0);
        check("to00.y", ptr_y, 0);
        press(0, 1);
        press(2, 1);
        check("clamp00.x", ptr_x, 0);
        check("clamp00.y", ptr_y, 0);

        // clamps at (14,14)
        press(3, 14);
        press(1, 14);
        press(1, 1);
        press(3, 1);
        check("clamp1414.x", ptr_x, 14);
        check("clamp1414.y", ptr_y, 14);

        // discarded outside CHOICE
        change_able_read = 1'b0;
        press(0, 1);
        press(2, 1);
        check("nochoice.x", ptr_x, 14);
        check("nochoice.y", ptr_y, 14);
        change_able_read = 1'b1;

        // re-centre
        control_set = 1'b1; tick(); control_set = 1'b0;
        check("centre.x", ptr_x, 7);
        check("centre.y", ptr_y, 7);

        // legal put at (7,7)
        put = 1'b1; tick();
        check("put1.legal", legal_put, 1);
        check("put1.wr_en", wr_en, 1);
        check("put1.wr_x", wr_x, 7);
        check("put1.wr_y", wr_y, 7);
        check("put1.wr_data", wr_data, 1);
        put = 1'b0; tick();
        check("put1.wr_en_off", wr_en, 0);
        change_turn = 1'b1; tick(); change_turn = 1'b0;
        check("turn1.player", player, 1);
        check("turn1.legal", legal_put, 0);
        check("put1.board", board[7][7], 1);

        // illegal put on white stone
        reset = 1'b1; poke_en = 1'b1; poke_x = 4'd7; poke_y = 4'd7; poke_v = 2'd2;
        tick();
        poke_en = 1'b0; reset = 1'b0;
        tick();
        put = 1'b1; tick();
        check("put2.legal", legal_put, 0);
        check("put2.wr_en", wr_en, 0);
        put = 1'b0; tick();
        check("put2.wr_en_late", wr_en, 0);
        change_turn = 1'b1; tick(); change_turn = 1'b0;
        check("turn2.player", player, 0);

        // control_set beats a same-cycle move
        press(2, 4);
        press(1, 5);
        check("at312.x", ptr_x, 3);
        check("at312.y", ptr_y, 12);
        control_set = 1'b1; move_right = 1'b1; tick();
        control_set = 1'b0; move_right = 1'b0;
        check("setprio.x", ptr_x, 7);
        check("setprio.y", ptr_y, 7);
        tick();

        // put and move together: move discarded, put uses pre-move pointer
        press(3, 1);
        put = 1'b1; move_up = 1'b1; tick();
        put = 1'b0; move_up = 1'b0;
        check("putmove.x", ptr_x, 8);
        check("putmove.y", ptr_y, 7);
        check("putmove.wr_x", wr_x, 8);
        check("putmove.legal", legal_put, 1);
        tick();
        change_turn = 1'b1; tick(); change_turn = 1'b0;
        check("turn3.player", player, 1);

        // reset during the write strobe
        press(3, 1);
        put = 1'b1; tick(); put = 1'b0;
        check("put4.wr_en", wr_en, 1);
        check("put4.wr_x", wr_x, 9);
        check("put4.wr_data", wr_data, 2);
        reset = 1'b1;
        #1;
        check_reset_vals("midreset");
        @(negedge clock);
        check("midreset.no_write", board[7][9], 0);
        reset = 1'b0;
        tick(); tick(); tick();
        check_reset_vals("hold");

        // randomized phase against the model
        reset = 1'b1; fill_en = 1'b1; fill_zero = 1'b0;
        model_reset();
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++)
                mboard[y][x] = int'(fill_val(x, y));
        tick();
        fill_en = 1'b0; reset = 1'b0;
        move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0; put = 1'b0;
        change_turn = 1'b0; control_set = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            compare_model();
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                compare_model();
                @(negedge clock);
                reset = 1'b0;
                continue;
            end
            if (mwen != 0) mboard[mwy][mwx] = mwd;
            move_up          = ($urandom_range(0, 99) < 30);
            move_down        = ($urandom_range(0, 99) < 30);
            move_left        = ($urandom_range(0, 99) < 30);
            move_right       = ($urandom_range(0, 99) < 30);
            put              = ($urandom_range(0, 99) < 30);
            change_able_read = ($urandom_range(0, 3) != 0);
            change_turn      = ($urandom_range(0, 9) == 0);
            control_set      = ($urandom_range(0, 39) == 0);
            model_step();
            @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
